// File: rtl/autoc_detect.sv
// autoc_detect: preamble detector on the autocorrelator output using an |I|+|Q| magnitude.
// Ports: clk/rst_n (async active-low); enable, in_stb, in_outputting qualify samples;
// si/sq signed 43-bit correlation; threshold vs mag[43:12]; hold_count run length;
// holdoff samples ignored after a detect; detect pulse with held peak_mag/peak_idx; busy when not IDLE.
module autoc_detect #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic signed [42:0]   si,
    input  logic signed [42:0]   sq,
    input  logic                 in_stb,
    input  logic                 in_outputting,
    input  logic [31:0]          threshold,
    input  logic [7:0]           hold_count,
    input  logic [CNT_WIDTH-1:0] holdoff,
    output logic                 detect,
    output logic [31:0]          peak_mag,
    output logic [CNT_WIDTH-1:0] peak_idx,
    output logic                 busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PEAK  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;
    logic                 qual, abort;
    logic [CNT_WIDTH-1:0] idx_q, idx1_q, idx2_q;
    logic                 v1_q, v2_q;
    logic [42:0]          ai_q, aq_q;
    logic [31:0]          m_q;
    logic [1:0]           state_q, state_d;
    logic [7:0]           run_q, run_d, hc_q, hc_raw, hc, run_inc;
    logic [31:0]          pk_mag_q, pk_mag_d, thr_q, thr;
    logic [CNT_WIDTH-1:0] pk_idx_q, pk_idx_d, cnt_q, cnt_d, ho_q;
    logic                 det_d, in_idle, above, new_pk;
    logic                 detect_q;
    logic [31:0]          peak_mag_q;
    logic [CNT_WIDTH-1:0] peak_idx_q;
    assign qual  = in_stb & in_outputting & enable;
    assign abort = ~(in_outputting & enable);
    // Stage 1 absolute values, stage 2 the compare slice of |I|+|Q|; the 44-bit sum
    // cannot overflow, so -2^42 on both rails yields exactly 2^43.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            idx1_q <= '0;
            idx2_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ai_q   <= '0;
            aq_q   <= '0;
            m_q    <= '0;
        end else begin
            idx_q <= !enable ? '0 : qual ? idx_q + CNT_WIDTH'(1) : idx_q;
            v1_q  <= qual;
            v2_q  <= v1_q & ~abort;
            if (qual) begin
                ai_q   <= si[42] ? 43'(-si) : 43'(si);
                aq_q   <= sq[42] ? 43'(-sq) : 43'(sq);
                idx1_q <= idx_q;
            end
            if (v1_q) begin
                m_q    <= 32'(({1'b0, ai_q} + {1'b0, aq_q}) >> 12);
                idx2_q <= idx1_q;
            end
        end
    end
    // Config is live while IDLE and frozen once a run starts.
    assign in_idle = state_q == S_IDLE;
    assign thr     = in_idle ? threshold : thr_q;
    assign hc_raw  = in_idle ? hold_count : hc_q;
    assign hc      = hc_raw == 8'd0 ? 8'd1 : hc_raw;
    assign above   = m_q >= thr;
    assign new_pk  = m_q > pk_mag_q;
    assign run_inc = run_q + 8'd1;
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        pk_mag_d = pk_mag_q;
        pk_idx_d = pk_idx_q;
        cnt_d    = cnt_q;
        det_d    = 1'b0;
        if (v2_q) begin
            case (state_q)
                S_IDLE: if (above) begin
                    run_d    = 8'd1;
                    pk_mag_d = m_q;
                    pk_idx_d = idx2_q;
                    state_d  = hc == 8'd1 ? S_PEAK : S_ARMED;
                end
                S_ARMED: if (above) begin
                    run_d    = run_inc;
                    pk_mag_d = new_pk ? m_q : pk_mag_q;
                    pk_idx_d = new_pk ? idx2_q : pk_idx_q;
                    state_d  = run_inc == hc ? S_PEAK : S_ARMED;
                end else begin
                    run_d   = '0;
                    state_d = S_IDLE;
                end
                S_PEAK: if (above) begin
                    // strict compare keeps the earliest index on ties
                    pk_mag_d = new_pk ? m_q : pk_mag_q;
                    pk_idx_d = new_pk ? idx2_q : pk_idx_q;
                end else begin
                    det_d   = 1'b1;
                    run_d   = '0;
                    cnt_d   = ho_q;
                    state_d = ho_q == '0 ? S_IDLE : S_HOLD;
                end
                default: begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = cnt_q == CNT_WIDTH'(1) ? S_IDLE : S_HOLD;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_q      <= '0;
            pk_mag_q   <= '0;
            pk_idx_q   <= '0;
            cnt_q      <= '0;
            thr_q      <= '0;
            hc_q       <= '0;
            ho_q       <= '0;
            detect_q   <= 1'b0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
        end else begin
            if (in_idle) begin
                thr_q <= threshold;
                hc_q  <= hold_count;
                ho_q  <= holdoff;
            end
            if (abort) begin
                state_q  <= S_IDLE;
                run_q    <= '0;
                detect_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                run_q    <= run_d;
                pk_mag_q <= pk_mag_d;
                pk_idx_q <= pk_idx_d;
                cnt_q    <= cnt_d;
                detect_q <= det_d;
                if (det_d) begin
                    peak_mag_q <= pk_mag_q;
                    peak_idx_q <= pk_idx_q;
                end
            end
        end
    end
    assign detect   = detect_q;
    assign peak_mag = peak_mag_q;
    assign peak_idx = peak_idx_q;
    assign busy     = ~in_idle;
endmodule
